// File: rtl/blake_nonce_sched.sv
// rtl/blake_nonce_sched.sv - nonce scan scheduler feeding a BLAKE-512 core; optional watchdog via BLAKE_SCHED_WDOG_EN
module blake_nonce_sched #(
  parameter int NONCE_W  = 32,
  parameter int TGT_W    = 64,
  parameter int WDOG_CYC = 64
) (
  input  logic                clk,
  input  logic                rstb,
  input  logic                job_valid,
  output logic                job_ready,
  input  logic [607:0]        job_hdr,
  input  logic [TGT_W-1:0]    job_target,
  input  logic [NONCE_W-1:0]  job_nonce_start,
  input  logic [NONCE_W-1:0]  job_nonce_end,
  input  logic                abort,
  output logic                core_ena,
  output logic [639:0]        core_din,
  input  logic [511:0]        core_dout,
  input  logic                core_rdy,
  output logic                res_valid,
  input  logic                res_ready,
  output logic [NONCE_W-1:0]  res_nonce,
  output logic [TGT_W-1:0]    res_hash_hi,
  output logic                job_done,
  output logic [31:0]         hash_count,
`ifdef BLAKE_SCHED_WDOG_EN
  output logic                wdog_err,
`endif
  output logic                busy
);

  typedef enum logic [2:0] {
    S_IDLE, S_LAUNCH, S_WAIT, S_CHECK, S_REPORT, S_DONE, S_DRAIN
  } state_t;

  state_t               state_q, state_d;
  logic [607:0]         hdr_q;
  logic [TGT_W-1:0]     target_q, hash_hi_q, res_hash_hi_q;
  logic [NONCE_W-1:0]   nonce_q, end_q, res_nonce_q;
  logic [31:0]          hash_count_q;
  logic                 core_ena_q, res_valid_q, job_done_q, busy_q;
  logic                 accept, capture, hit_load, nonce_inc;
  logic                 hit, last_nonce, wdog_expired;
  logic                 unused_ok;

  assign hit        = (hash_hi_q <= target_q);
  assign last_nonce = (nonce_q == end_q);
  assign unused_ok  = ^{core_dout[511-TGT_W:0], 1'(WDOG_CYC)};

`ifdef BLAKE_SCHED_WDOG_EN
  localparam int WD_W = $clog2(WDOG_CYC) + 1;
  logic [WD_W-1:0] wd_cnt_q;
  logic            wdog_err_q;
  assign wdog_expired = (wd_cnt_q == WD_W'(WDOG_CYC - 1));
  assign wdog_err     = wdog_err_q;
`else
  assign wdog_expired = 1'b0;
`endif

  always_comb begin
    state_d   = state_q;
    accept    = 1'b0;
    capture   = 1'b0;
    hit_load  = 1'b0;
    nonce_inc = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (job_valid) begin
          accept  = 1'b1;
          state_d = (job_nonce_start > job_nonce_end) ? S_DONE : S_LAUNCH;
        end
      end
      S_LAUNCH: state_d = abort ? S_IDLE : S_WAIT;
      S_WAIT: begin
        // A result arriving together with abort is dropped, not counted.
        if (core_rdy) begin
          capture = ~abort;
          state_d = abort ? S_IDLE : S_CHECK;
        end else if (wdog_expired) begin
          state_d = S_IDLE;
        end else if (abort) begin
          state_d = S_DRAIN;
        end
      end
      S_CHECK: begin
        if (abort) begin
          state_d = S_IDLE;
        end else if (hit) begin
          hit_load = 1'b1;
          state_d  = S_REPORT;
        end else if (last_nonce) begin
          state_d = S_DONE;
        end else begin
          nonce_inc = 1'b1;
          state_d   = S_LAUNCH;
        end
      end
      S_REPORT: begin
        if (abort) begin
          state_d = S_IDLE;
        end else if (res_ready) begin
          nonce_inc = ~last_nonce;
          state_d   = last_nonce ? S_DONE : S_LAUNCH;
        end
      end
      S_DONE:  state_d = S_IDLE;
      S_DRAIN: if (core_rdy || wdog_expired) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rstb) begin
      state_q       <= S_IDLE;
      hdr_q         <= '0;
      target_q      <= '0;
      hash_hi_q     <= '0;
      res_hash_hi_q <= '0;
      nonce_q       <= '0;
      end_q         <= '0;
      res_nonce_q   <= '0;
      hash_count_q  <= '0;
      core_ena_q    <= 1'b0;
      res_valid_q   <= 1'b0;
      job_done_q    <= 1'b0;
      busy_q        <= 1'b0;
`ifdef BLAKE_SCHED_WDOG_EN
      wd_cnt_q      <= '0;
      wdog_err_q    <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      core_ena_q  <= (state_d == S_LAUNCH);
      res_valid_q <= (state_d == S_REPORT);
      job_done_q  <= (state_d == S_DONE);
      busy_q      <= (state_d != S_IDLE);
      if (accept) begin
        hdr_q        <= job_hdr;
        target_q     <= job_target;
        nonce_q      <= job_nonce_start;
        end_q        <= job_nonce_end;
        hash_count_q <= '0;
      end
      if (capture) begin
        hash_hi_q <= core_dout[511 -: TGT_W];
        if (hash_count_q != 32'hFFFF_FFFF) hash_count_q <= hash_count_q + 32'd1;
      end
      if (hit_load) begin
        res_nonce_q   <= nonce_q;
        res_hash_hi_q <= hash_hi_q;
      end
      if (nonce_inc) nonce_q <= nonce_q + NONCE_W'(1);
`ifdef BLAKE_SCHED_WDOG_EN
      // Counts cycles since core_ena while a hash is outstanding.
      if (state_q == S_LAUNCH) wd_cnt_q <= '0;
      else if (state_q == S_WAIT || state_q == S_DRAIN) wd_cnt_q <= wd_cnt_q + WD_W'(1);
      if ((state_q == S_WAIT || state_q == S_DRAIN) && wdog_expired && !core_rdy)
        wdog_err_q <= 1'b1;
`endif
    end
  end

  assign job_ready   = (state_q == S_IDLE) & ~rstb;
  assign core_ena    = core_ena_q;
  assign core_din    = {hdr_q, nonce_q};
  assign res_valid   = res_valid_q;
  assign res_nonce   = res_nonce_q;
  assign res_hash_hi = res_hash_hi_q;
  assign job_done    = job_done_q;
  assign hash_count  = hash_count_q;
  assign busy        = busy_q;

endmodule

// File: tb/tb_blake_nonce_sched.sv
// tb/tb_blake_nonce_sched.sv - directed scoreboard bench for blake_nonce_sched (BLAKE_SCHED_WDOG_EN optional)
module tb_blake_nonce_sched;
  localparam int L = 20;

  logic          clk = 1'b0;
  logic          rstb;
  logic          job_valid, job_ready;
  logic [607:0]  job_hdr;
  logic [63:0]   job_target;
  logic [31:0]   job_nonce_start, job_nonce_end;
  logic          abort;
  logic          core_ena;
  logic [639:0]  core_din;
  logic [511:0]  core_dout;
  logic          core_rdy;
  logic          res_valid, res_ready;
  logic [31:0]   res_nonce;
  logic [63:0]   res_hash_hi;
  logic          job_done;
  logic [31:0]   hash_count;
  logic          busy;
`ifdef BLAKE_SCHED_WDOG_EN
  logic          wdog_err;
`endif

  always #5 clk = ~clk;

  blake_nonce_sched #(.NONCE_W(32), .TGT_W(64), .WDOG_CYC(64)) dut (
    .clk(clk), .rstb(rstb),
    .job_valid(job_valid), .job_ready(job_ready), .job_hdr(job_hdr),
    .job_target(job_target), .job_nonce_start(job_nonce_start), .job_nonce_end(job_nonce_end),
    .abort(abort), .core_ena(core_ena), .core_din(core_din), .core_dout(core_dout),
    .core_rdy(core_rdy), .res_valid(res_valid), .res_ready(res_ready),
    .res_nonce(res_nonce), .res_hash_hi(res_hash_hi), .job_done(job_done),
    .hash_count(hash_count),
`ifdef BLAKE_SCHED_WDOG_EN
    .wdog_err(wdog_err),
`endif
    .busy(busy)
  );

  typedef struct packed { logic [31:0] n; logic [63:0] h; } hit_t;

  int            n_checks = 0;
  int            n_fail   = 0;
  int            cyc      = 0;
  int            acc_cyc;
  int            ena_count = 0, done_count = 0, res_seen = 0, hs_cyc = -1;
  int            ena_cycq[$];
  logic [31:0]   exp_din_q[$];
  hit_t          exp_hit_q[$];
  logic [607:0]  cur_hdr;
  bit            hit_en = 1'b0, core_mute = 1'b0;
  logic [31:0]   hit_nonce = '0;
  logic [63:0]   hit_val = '0;

  task automatic chk(input string tag, input logic [639:0] obs, input logic [639:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [511:0] model_hash(input logic [31:0] n);
    logic [63:0] top;
    top = (hit_en && n == hit_nonce) ? hit_val : (64'h8000_0000_0000_0000 | {32'h0, n});
    return {top, {14{n}}};
  endfunction

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  // Core model: rdy is visible L cycles after the cycle in which ena is high.
  initial begin
    logic [31:0] n;
    core_rdy  = 1'b0;
    core_dout = '0;
    forever begin
      @(negedge clk);
      if (core_ena && !core_mute) begin
        n = core_din[31:0];
        repeat (L) @(negedge clk);
        core_dout = model_hash(n);
        core_rdy  = 1'b1;
        @(negedge clk);
        core_rdy  = 1'b0;
      end
    end
  end

  // Scoreboard side: pop expected launches and hits as the DUT produces them.
  initial forever begin
    logic [31:0] e;
    hit_t        h;
    @(negedge clk);
    if (core_ena) begin
      ena_count++;
      ena_cycq.push_back(cyc);
      if (exp_din_q.size() == 0) chk("ena_unexpected", 640'(exp_din_q.size()), 640'd1);
      else begin
        e = exp_din_q.pop_front();
        chk("din_nonce", 640'(core_din[31:0]), 640'(e));
        chk("din_hdr", 640'(core_din[639:32]), 640'(cur_hdr));
      end
    end
    if (job_done) done_count++;
    if (res_valid) res_seen++;
    if (res_valid && res_ready) begin
      hs_cyc = cyc;
      if (exp_hit_q.size() == 0) chk("hit_unexpected", 640'(exp_hit_q.size()), 640'd1);
      else begin
        h = exp_hit_q.pop_front();
        chk("res_nonce", 640'(res_nonce), 640'(h.n));
        chk("res_hash_hi", 640'(res_hash_hi), 640'(h.h));
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: observed running expected finished");
    $fatal(1, "timeout");
  end

  task automatic send_job(input logic [63:0] tgt, input logic [31:0] s, input logic [31:0] e);
    @(negedge clk);
    cur_hdr         = {19{32'hA5C3_0F1E ^ s}};
    job_hdr         = cur_hdr;
    job_target      = tgt;
    job_nonce_start = s;
    job_nonce_end   = e;
    job_valid       = 1'b1;
    chk("job_ready_idle", 640'(job_ready), 640'd1);
    @(posedge clk);
    #1;
    job_valid = 1'b0;
    acc_cyc   = cyc;
  endtask

  task automatic wait_done(input int budget, output bit ok, output int at);
    ok = 1'b0;
    at = -1;
    for (int i = 0; i < budget && !ok; i++) begin
      @(negedge clk);
      if (job_done) begin ok = 1'b1; at = cyc; end
    end
  endtask

  task automatic wait_resv(input int budget, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < budget && !ok; i++) begin
      @(negedge clk);
      if (res_valid) ok = 1'b1;
    end
  endtask

  initial begin
    bit ok;
    int at, e0, d0, stall_hi;
    rstb = 1'b1; job_valid = 1'b0; job_hdr = '0; job_target = '0;
    job_nonce_start = '0; job_nonce_end = '0; abort = 1'b0; res_ready = 1'b1;
    cur_hdr = '0;

    // Reset state
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_job_ready", 640'(job_ready), 640'd0);
    chk("rst_busy", 640'(busy), 640'd0);
    chk("rst_core_ena", 640'(core_ena), 640'd0);
    chk("rst_res_valid", 640'(res_valid), 640'd0);
    chk("rst_job_done", 640'(job_done), 640'd0);
    chk("rst_hash_count", 640'(hash_count), 640'd0);
    chk("rst_core_din", core_din, 640'd0);
    chk("rst_res_nonce", 640'(res_nonce), 640'd0);
    @(posedge clk); #1;
    rstb = 1'b0;
    #1;
    chk("post_rst_job_ready", 640'(job_ready), 640'd1);

    // Miss-only scan 5..7
    ena_cycq.delete();
    e0 = ena_count; d0 = done_count;
    exp_din_q.push_back(32'd5); exp_din_q.push_back(32'd6); exp_din_q.push_back(32'd7);
    send_job(64'h0, 32'd5, 32'd7);
    wait_done(300, ok, at);
    chk("t1_done_seen", 640'(ok), 640'd1);
    @(negedge clk);
    chk("t1_done_pulse_1cyc", 640'(job_done), 640'd0);
    chk("t1_ena_count", 640'(ena_count - e0), 640'd3);
    chk("t1_gap0", 640'(ena_cycq.size() > 1 ? ena_cycq[1] - ena_cycq[0] : 0), 640'(L + 2));
    chk("t1_gap1", 640'(ena_cycq.size() > 2 ? ena_cycq[2] - ena_cycq[1] : 0), 640'(L + 2));
    chk("t1_hash_count", 640'(hash_count), 640'd3);
    chk("t1_done_count", 640'(done_count - d0), 640'd1);
    chk("t1_no_res", 640'(res_seen), 640'd0);
    chk("t1_job_ready", 640'(job_ready), 640'd1);

    // Hit on nonce 6 with target equal to hash (inclusive compare), stalled report
    hit_en = 1'b1; hit_nonce = 32'd6; hit_val = 64'h10;
    res_ready = 1'b0;
    e0 = ena_count;
    for (int n = 5; n <= 8; n++) exp_din_q.push_back(32'(n));
    exp_hit_q.push_back('{n: 32'd6, h: 64'h10});
    send_job(64'h10, 32'd5, 32'd8);
    wait_resv(300, ok);
    chk("t2_res_valid_seen", 640'(ok), 640'd1);
    chk("t2_res_nonce_direct", 640'(res_nonce), 640'd6);
    chk("t2_res_hash_direct", 640'(res_hash_hi), 640'h10);
    d0 = ena_count; stall_hi = 0;
    repeat (10) begin
      @(negedge clk);
      if (res_valid && res_nonce == 32'd6) stall_hi++;
    end
    chk("t2_stall_held", 640'(stall_hi), 640'd10);
    chk("t2_stall_no_ena", 640'(ena_count - d0), 640'd0);
    @(posedge clk); #1; res_ready = 1'b1;
    @(posedge clk); #1; res_ready = 1'b0;
    chk("t2_res_valid_drop", 640'(res_valid), 640'd0);
    chk("t2_resume_ena", 640'(core_ena), 640'd1);
    chk("t2_resume_nonce", 640'(core_din[31:0]), 640'd7);
    wait_done(300, ok, at);
    chk("t2_done_seen", 640'(ok), 640'd1);
    chk("t2_hash_count", 640'(hash_count), 640'd4);
    chk("t2_ena_count", 640'(ena_count - e0), 640'd4);
    chk("t2_hit_q_empty", 640'(exp_hit_q.size()), 640'd0);
    hit_en = 1'b0; res_ready = 1'b1;

    // Empty range: start > end
    @(posedge clk); #1;
    e0 = ena_count;
    send_job(64'hFFFF, 32'd9, 32'd3);
    wait_done(10, ok, at);
    chk("t3_done_seen", 640'(ok), 640'd1);
    chk("t3_done_latency", 640'(at), 640'(acc_cyc));
    chk("t3_no_ena", 640'(ena_count - e0), 640'd0);
    chk("t3_hash_count", 640'(hash_count), 640'd0);

    // Top of nonce space: exactly one hash, no wrap
    @(posedge clk); #1;
    e0 = ena_count;
    exp_din_q.push_back(32'hFFFF_FFFF);
    send_job(64'h0, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    wait_done(100, ok, at);
    chk("t4_done_seen", 640'(ok), 640'd1);
    chk("t4_hash_count", 640'(hash_count), 640'd1);
    repeat (30) @(negedge clk);
    chk("t4_no_wrap", 640'(ena_count - e0), 640'd1);
    chk("t4_idle", 640'(busy), 640'd0);

    // Abort five cycles into WAIT drains the in-flight hash
    @(posedge clk); #1;
    e0 = ena_count; d0 = done_count;
    exp_din_q.push_back(32'd10);
    send_job(64'h0, 32'd10, 32'd20);
    repeat (5) @(posedge clk);
    #1; abort = 1'b1;
    @(posedge clk); #1; abort = 1'b0;
    repeat (14) @(posedge clk);
    #1;
    chk("t5_drain_not_ready", 640'(job_ready), 640'd0);
    chk("t5_drain_busy", 640'(busy), 640'd1);
    @(posedge clk); #1;
    chk("t5_ready_after_rdy", 640'(job_ready), 640'd1);
    repeat (30) @(negedge clk);
    chk("t5_ena_count", 640'(ena_count - e0), 640'd1);
    chk("t5_no_done", 640'(done_count - d0), 640'd0);
    chk("t5_hash_count_held", 640'(hash_count), 640'd0);

`ifdef BLAKE_SCHED_WDOG_EN
    // Core never answers: watchdog returns the scheduler to IDLE
    core_mute = 1'b1;
    @(posedge clk); #1;
    d0 = done_count;
    exp_din_q.push_back(32'd0);
    send_job(64'h0, 32'd0, 32'd0);
    repeat (30) @(posedge clk);
    #1;
    chk("t6_wdog_not_yet", 640'(wdog_err), 640'd0);
    repeat (36) @(posedge clk);
    #1;
    chk("t6_wdog_err", 640'(wdog_err), 640'd1);
    chk("t6_job_ready", 640'(job_ready), 640'd1);
    chk("t6_idle", 640'(busy), 640'd0);
    chk("t6_no_done", 640'(done_count - d0), 640'd0);
    core_mute = 1'b0;
`endif

    chk("sb_din_empty", 640'(exp_din_q.size()), 640'd0);
    chk("sb_hit_empty", 640'(exp_hit_q.size()), 640'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule

// File: doc/blake_nonce_sched.md
Name: blake_nonce_sched

Overview:
- Job scheduler that sits directly upstream of the BLAKE-512 hashing core and consumes its result.
- Accepts a 76-byte header template, a target and a nonce range.
- Assembles each 80-byte message by appending the nonce, pulses the core's ena, and waits for rdy.
- Compares the top 64 hash bits against the target and reports hits on a valid/ready result port.

Parameters:
- NONCE_W, 32: nonce width in bits. Fixed at 32 so din stays 640 bits.
- TGT_W, 64: number of top hash bits compared against the target.
- WDOG_CYC, 64: watchdog limit in cycles. Used only when BLAKE_SCHED_WDOG_EN is defined.

Ports:
- clk  in  1  clock.
- rstb  in  1  reset: synchronous, active-high (1 = reset). The name is kept for codebase consistency.
- job_valid  in  1  job offer.
- job_ready  out  1  scheduler can accept a job.
- job_hdr  in  608  header bytes 0..75, MSB is the first byte.
- job_target  in  TGT_W  hit threshold.
- job_nonce_start  in  NONCE_W  first nonce.
- job_nonce_end  in  NONCE_W  last nonce, inclusive.
- abort  in  1  cancel the current job.
- core_ena  out  1  one-cycle start pulse to the core.
- core_din  out  640  {hdr_reg, nonce}, with the nonce big-endian in bits [31:0].
- core_dout  in  512  core hash.
- core_rdy  in  1  core result valid.
- res_valid  out  1  hit available.
- res_ready  in  1  hit consumed.
- res_nonce  out  NONCE_W  nonce that hit.
- res_hash_hi  out  TGT_W  core_dout[511:512-TGT_W] for that nonce.
- job_done  out  1  one-cycle pulse when the range is exhausted.
- hash_count  out  32  hashes completed in the current job; saturates at 32'hFFFFFFFF.
- busy  out  1  state is not IDLE.

Behaviour:
- Reset: state=IDLE. core_ena, res_valid, job_done, busy = 0. hash_count, nonce, hdr_reg, target_reg, res_* = 0. job_ready = 0 while rstb=1 and 1 in IDLE after reset.
- job_ready = (state==IDLE) & ~rstb.
- IDLE:
  - Job accepted on job_valid & job_ready. Latch hdr, target, start and end; nonce<=start; hash_count<=0.
  - If start > end, go to DONE: empty range, no hashes.
  - Otherwise go to LAUNCH.
- LAUNCH: core_ena=1 for exactly this cycle. core_din is registered and stays stable from LAUNCH until core_rdy. Next state is WAIT.
- WAIT:
  - On core_rdy, capture hash_hi = core_dout[511:512-TGT_W] and increment hash_count (saturating). Next state is CHECK.
  - core_rdy in any state other than WAIT or DRAIN is ignored.
- CHECK:
  - hit = (hash_hi <= target_reg), unsigned.
  - On a hit, load res_nonce and res_hash_hi and go to REPORT.
  - On a miss with nonce==end, go to DONE.
  - On a miss otherwise, nonce<=nonce+1 and go to LAUNCH.
- REPORT:
  - res_valid=1 and res_* held stable until res_ready.
  - On the handshake cycle: if nonce==end go to DONE, else nonce+1 and go to LAUNCH.
  - res_valid drops the cycle after the handshake.
- DONE: job_done=1 for one cycle, then IDLE.
- Throughput: a missed nonce costs L+2 cycles, where L is the core's ena-to-rdy latency. A hit adds at least 1 cycle plus res_ready stall.
- Wrap: nonce never wraps. With end=32'hFFFFFFFF, the job terminates after that nonce.
- abort:
  - Outside WAIT and DRAIN, abort goes to IDLE next cycle. res_valid is cleared, no job_done pulse, hash_count is held.
  - In WAIT, abort goes to DRAIN, which waits for core_rdy, discards the result, then goes to IDLE. This prevents a new launch colliding with an in-flight hash.
  - abort in DRAIN or IDLE has no effect.
- Simultaneous events:
  - abort and core_rdy in the same WAIT cycle: the result is discarded and the state goes straight to IDLE.
  - abort and res_ready in REPORT: abort wins and the result counts as consumed.
- Reset mid-operation returns to IDLE in the next cycle. An in-flight core hash is not tracked; the core shares rstb, so the system is consistent.

Optional Feature:
- Macro: BLAKE_SCHED_WDOG_EN.
- Defined:
  - A counter runs in WAIT and DRAIN. If core_rdy is not seen within WDOG_CYC cycles of core_ena, a sticky output wdog_err (1 bit, reset 0) is set.
  - The state goes to IDLE with no job_done. wdog_err clears only on reset.
- Not defined: the wdog_err port and counter are absent, and WAIT and DRAIN wait indefinitely.

Test Plan:
- Core model with L=20; job start=5, end=7, target=0 (no hits) -> three core_ena pulses 22 cycles apart; core_din[31:0] = 5, 6, 7; one job_done; hash_count=3; res_valid never 1.
- Core returns hash_hi=64'h10 for nonce 6; target=64'h10 -> res_valid with res_nonce=6 and res_hash_hi=64'h10; res_ready held 0 for 10 cycles stalls the scheduler (no core_ena); scanning resumes at nonce 7 after the handshake.
- start=9, end=3 -> job_done 1 cycle after accept, no core_ena, hash_count=0.
- start=end=32'hFFFFFFFF -> exactly one hash, then job_done; no wrap to 0.
- abort asserted 5 cycles into WAIT -> no further core_ena; job_ready returns 1 the cycle after core_rdy; no job_done pulse.
- With BLAKE_SCHED_WDOG_EN and WDOG_CYC=64, core never asserts rdy -> wdog_err=1 after 64 cycles, state back in IDLE, job_ready=1.
